// File: rtl/peripheral_uart_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART peripheral: register map,
// STATUS bit positions, TX drain state encoding and the baud divider helper.
package peripheral_uart_fifo_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;
    localparam logic [3:0] ADDR_RXCNT  = 4'h6;
    localparam logic [3:0] ADDR_TXCNT  = 4'h8;
    localparam logic [3:0] ADDR_ERRCLR = 4'hA;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_TX_ACTIVE   = 4;
    localparam int ST_RX_OVERRUN  = 5;
    localparam int ST_RX_FRAME    = 6;
    localparam int ST_TX_OVERFLOW = 7;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LOAD      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

    function automatic int baud_div(input int freq, input int rate);
        return (rate > 0 && freq >= rate) ? freq / rate : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy counter; a pop on a full
// FIFO frees the slot for a push in the same cycle.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [width-1:0]       wdata,
    output logic [width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign full  = (count == (aw + 1)'(depth));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART core: one-byte transmitter with busy flag and a receiver that
// holds each byte in rx_data/rx_avail until acknowledged.
module uart_core import peripheral_uart_fifo_pkg::*; #(
    parameter int clk_freq = 100000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack
);

    localparam int div = baud_div(clk_freq, baud);
    localparam int dw  = $clog2(div) + 1;

    logic [9:0]    tx_shift;
    logic [3:0]    tx_bits;
    logic [dw-1:0] tx_cnt;

    assign tx = tx_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '1;
            tx_bits  <= '0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
        end else if (!tx_busy) begin
            if (tx_wr) begin
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx_bits  <= 4'd9;
                tx_cnt   <= dw'(div - 1);
                tx_busy  <= 1'b1;
            end
        end else if (tx_cnt == '0) begin
            if (tx_bits == '0) begin
                tx_busy <= 1'b0;
            end else begin
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bits  <= tx_bits - 1'b1;
                tx_cnt   <= dw'(div - 1);
            end
        end else begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_s3;
    logic          rx_busy;
    logic [3:0]    rx_bits;
    logic [dw-1:0] rx_cnt;
    logic [7:0]    rx_shift;

    // Start is a falling edge, so a line left low after a bad stop bit
    // is not mistaken for a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_busy  <= 1'b0;
            rx_bits  <= '0;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_avail <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_error <= 1'b0;
            if (rx_ack) rx_avail <= 1'b0;
            if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_bits <= '0;
                    rx_cnt  <= dw'(div / 2 - 1);
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else if (rx_bits == '0) begin
                if (rx_s2) begin
                    rx_busy <= 1'b0;
                end else begin
                    rx_bits <= 4'd1;
                    rx_cnt  <= dw'(div - 1);
                end
            end else if (rx_bits != 4'd9) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bits  <= rx_bits + 1'b1;
                rx_cnt   <= dw'(div - 1);
            end else begin
                rx_busy <= 1'b0;
                if (rx_s2) begin
                    rx_data  <= rx_shift;
                    rx_avail <= 1'b1;
                end else begin
                    rx_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/peripheral_uart_fifo.sv
// Bus-mapped UART peripheral: TX/RX byte FIFOs around the uart core, sticky
// error flags, interrupt enables and a drain FSM feeding the transmitter.
module peripheral_uart_fifo import peripheral_uart_fifo_pkg::*; #(
    parameter int clk_freq = 100000000,
    parameter int baud     = 115200,
    parameter int tx_depth = 16,
    parameter int rx_depth = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);

    localparam int tx_cw = $clog2(tx_depth) + 1;
    localparam int rx_cw = $clog2(rx_depth) + 1;

    logic             wr_en;
    logic             rd_en;
    logic             errclr;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [tx_cw-1:0] tx_count;
    logic [7:0]       tx_head;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic [rx_cw-1:0] rx_count;
    logic [7:0]       rx_head;
    logic             rx_capture;
    logic             tx_wr;
    logic             tx_busy;
    logic [7:0]       rx_data;
    logic             rx_avail;
    logic             rx_error;
    logic             rx_ack;
    logic [2:0]       ctrl;
    logic             rx_overrun;
    logic             rx_frame_err;
    logic             tx_overflow;
    logic             set_overrun;
    logic             set_overflow;
    logic [15:0]      status;
    logic [15:0]      rd_data;
    logic             unused_bits;
    tx_state_t        state;
    tx_state_t        state_next;

    assign unused_bits = ^{d_in[15:8], d_in[4:3]};

    sync_fifo #(.width(8), .depth(tx_depth)) u_tx_fifo (
        .clk, .rst,
        .push(tx_push), .pop(tx_pop), .wdata(d_in[7:0]), .rdata(tx_head),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.width(8), .depth(rx_depth)) u_rx_fifo (
        .clk, .rst,
        .push(rx_push), .pop(rx_pop), .wdata(rx_data), .rdata(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart_core #(.clk_freq(clk_freq), .baud(baud)) u_uart (
        .clk, .rst,
        .tx_wr, .tx_data(tx_head), .tx_busy, .tx(uart_tx),
        .rx(uart_rx), .rx_data, .rx_avail, .rx_error, .rx_ack
    );

    // A write wins over a simultaneous read, which then only zeroes d_out.
    always_comb begin
        wr_en        = cs && wr;
        rd_en        = cs && rd && !wr;
        errclr       = wr_en && (addr == ADDR_ERRCLR);
        tx_push      = wr_en && (addr == ADDR_DATA);
        rx_pop       = rd_en && (addr == ADDR_DATA) && !rx_empty;
        rx_capture   = rx_avail && !rx_ack;
        rx_push      = rx_capture && (!rx_full || rx_pop);
        set_overrun  = rx_capture && rx_full && !rx_pop;
        set_overflow = tx_push && tx_full && !tx_pop;
    end

    // state        | meaning
    // TX_IDLE      | waiting for a byte in the TX FIFO and an idle transmitter
    // TX_LOAD      | pop FIFO head into the core, tx_wr pulse
    // TX_WAIT_BUSY | waiting for the core to accept the byte
    // TX_WAIT_DONE | frame on the line, waiting for tx_busy to drop
    always_ff @(posedge clk) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        tx_wr      = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy) state_next = TX_LOAD;
            end
            TX_LOAD: begin
                tx_pop     = 1'b1;
                tx_wr      = 1'b1;
                state_next = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (tx_busy) state_next = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) state_next = TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_ACTIVE]   = (state != TX_IDLE);
        status[ST_RX_OVERRUN]  = rx_overrun;
        status[ST_RX_FRAME]    = rx_frame_err;
        status[ST_TX_OVERFLOW] = tx_overflow;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA:   rd_data = rx_empty ? 16'h0000 : {8'h00, rx_head};
            ADDR_STATUS: rd_data = status;
            ADDR_CTRL:   rd_data = {13'd0, ctrl};
            ADDR_RXCNT:  rd_data = 16'(rx_count);
            ADDR_TXCNT:  rd_data = 16'(tx_count);
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else if (cs && rd && wr) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_data;
        end
    end

    // Sticky flags: a set arriving in the same cycle as its clear survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl         <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overflow  <= 1'b0;
            rx_ack       <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (wr_en && (addr == ADDR_CTRL)) ctrl <= d_in[2:0];
            rx_overrun   <= (rx_overrun   && !(errclr && d_in[5])) || set_overrun;
            rx_frame_err <= (rx_frame_err && !(errclr && d_in[6])) || rx_error;
            tx_overflow  <= (tx_overflow  && !(errclr && d_in[7])) || set_overflow;
            rx_ack       <= rx_capture;
            irq          <= (!rx_empty && ctrl[0]) || (tx_empty && ctrl[1]) ||
                            ((rx_overrun || rx_frame_err || tx_overflow) && ctrl[2]);
        end
    end

endmodule

// File: tb/tb_peripheral_uart_fifo.sv
// Scoreboard bench for peripheral_uart_fifo: bus reads and serial TX frames
// are checked by independent monitors against a queue-based reference model.
module tb_peripheral_uart_fifo;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int TXD      = 4;
    localparam int RXD      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] d_in = '0;
    logic [15:0] d_out;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic        irq;

    always #5 clk = ~clk;

    peripheral_uart_fifo #(
        .clk_freq(CLK_FREQ), .baud(BAUD), .tx_depth(TXD), .rx_depth(RXD)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_rd_q[$];
    string       exp_name_q[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_q[$];
    bit          ovr_m = 0;
    bit          ferr_m = 0;
    bit          tofl_m = 0;
    bit          mon_busy = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] st(input int txcnt, input bit txact);
        logic [15:0] s;
        s = '0;
        s[0] = (rx_q.size() != 0);
        s[1] = (rx_q.size() == RXD);
        s[2] = (txcnt == 0);
        s[3] = (txcnt == TXD);
        s[4] = txact;
        s[5] = ovr_m;
        s[6] = ferr_m;
        s[7] = tofl_m;
        return s;
    endfunction

    // Read-data monitor: every cs&rd cycle produces one d_out update.
    always @(posedge clk) begin
        if (cs && rd) begin
            #1;
            if (exp_rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got 0x%04h with no expected read", d_out);
            end else begin
                check(exp_name_q.pop_front(), d_out, exp_rd_q.pop_front());
            end
        end
    end

    // Serial TX monitor: samples each bit mid-period at the configured baud.
    initial begin
        logic [9:0] f;
        logic [7:0] e;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst || uart_tx !== 1'b0) continue;
            mon_busy = 1;
            ab = 0;
            for (int i = 0; i < 10; i++) begin
                repeat ((i == 0) ? DIV / 2 : DIV) begin
                    @(negedge clk);
                    if (rst) ab = 1;
                end
                f[i] = uart_tx;
            end
            if (!ab) begin
                tests++;
                if (tx_exp.size() == 0) begin
                    fails++;
                    $display("FAIL tx_frame: got unexpected frame data=0x%02h", f[8:1]);
                end else begin
                    e = tx_exp.pop_front();
                    if (f[0] !== 1'b0 || f[9] !== 1'b1 || f[8:1] !== e) begin
                        fails++;
                        $display("FAIL tx_frame: got start=%b data=0x%02h stop=%b expected data=0x%02h",
                                 f[0], f[8:1], f[9], e);
                    end
                end
            end
            mon_busy = 0;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1; wr = 1; rd = 0; addr = a; d_in = d;
        @(negedge clk);
        cs = 0; wr = 0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [15:0] e, input string n);
        exp_rd_q.push_back(e);
        exp_name_q.push_back(n);
        @(negedge clk);
        cs = 1; rd = 1; wr = 0; addr = a;
        @(negedge clk);
        cs = 0; rd = 0;
    endtask

    task automatic bus_rdwr(input logic [3:0] a);
        exp_rd_q.push_back(16'h0000);
        exp_name_q.push_back("rd_wr_collision");
        @(negedge clk);
        cs = 1; rd = 1; wr = 1; addr = a; d_in = 16'h0000;
        @(negedge clk);
        cs = 0; rd = 0; wr = 0;
    endtask

    task automatic tx_write(input logic [7:0] b, input bit accept);
        logic [7:0] hi;
        hi = 8'($urandom);
        bus_write(4'h0, {hi, b});
        if (accept) tx_exp.push_back(b);
        else tofl_m = 1;
    endtask

    task automatic rx_read();
        logic [7:0] e;
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        bus_read(4'h0, {8'h00, e}, "rx_data");
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (DIV) @(negedge clk);
        if (stop_ok) begin
            if (rx_q.size() < RXD) rx_q.push_back(b);
            else ovr_m = 1;
        end else begin
            ferr_m = 1;
        end
    endtask

    task automatic wait_tx_done();
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || mon_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL tx_drain: got %0d frames pending expected 0", tx_exp.size());
        end
        repeat (DIV + 5) @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         n;
        bit         hit;

        repeat (4) @(negedge clk);
        rst = 0;
        @(negedge clk);

        // reset state
        check("irq_reset", {15'd0, irq}, 16'h0000);
        check("tx_idle_reset", {15'd0, uart_tx}, 16'h0001);
        bus_read(4'h2, st(0, 0), "status_reset");
        bus_read(4'h6, 16'h0000, "rxcnt_reset");
        bus_read(4'h8, 16'h0000, "txcnt_reset");
        bus_read(4'h4, 16'h0000, "ctrl_reset");
        bus_read(4'hC, 16'h0000, "unmapped_c");
        bus_read(4'hA, 16'h0000, "errclr_read");

        // CTRL width and tx_empty interrupt
        bus_write(4'h4, 16'hFFFF);
        bus_read(4'h4, 16'h0007, "ctrl_mask");
        bus_write(4'h4, 16'h0002);
        repeat (2) @(negedge clk);
        check("irq_tx_empty", {15'd0, irq}, 16'h0001);

        // three-byte transmit
        tx_write(8'h41, 1);
        tx_write(8'h42, 1);
        tx_write(8'h43, 1);
        repeat (5) @(negedge clk);
        bus_read(4'h8, 16'h0002, "txcnt_sending");
        check("irq_tx_pending", {15'd0, irq}, 16'h0000);
        bus_read(4'h2, st(2, 1), "status_sending");
        wait_tx_done();
        bus_read(4'h8, 16'h0000, "txcnt_drained");
        repeat (2) @(negedge clk);
        check("irq_tx_drained", {15'd0, irq}, 16'h0001);

        // overflow while the transmitter is busy
        tx_write(8'($urandom), 1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < TXD; i++) tx_write(8'($urandom), 1);
        tx_write(8'($urandom), 0);
        bus_read(4'h2, st(TXD, 1), "status_overflow");
        bus_rdwr(4'hA);
        bus_write(4'hA, 16'h0080);
        tofl_m = 0;
        bus_read(4'h2, st(TXD, 1), "status_ovf_cleared");
        wait_tx_done();

        // random transmit batches
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, TXD);
            for (int i = 0; i < n; i++) begin
                tx_write(8'($urandom), 1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_tx_done();
        end

        // RX overrun with no reads
        bus_write(4'h4, 16'h0001);
        for (int i = 0; i < RXD + 1; i++) send_frame(8'($urandom), 1);
        bus_read(4'h6, 16'(RXD), "rxcnt_full");
        bus_read(4'h2, st(0, 0), "status_overrun");
        check("irq_rx_nonempty", {15'd0, irq}, 16'h0001);
        for (int i = 0; i < RXD; i++) rx_read();
        rx_read();
        bus_read(4'h6, 16'h0000, "rxcnt_empty_read");
        repeat (2) @(negedge clk);
        check("irq_rx_empty", {15'd0, irq}, 16'h0000);
        bus_write(4'h4, 16'h0004);
        repeat (2) @(negedge clk);
        check("irq_err_overrun", {15'd0, irq}, 16'h0001);
        bus_write(4'hA, 16'h0020);
        ovr_m = 0;
        repeat (2) @(negedge clk);
        check("irq_err_cleared", {15'd0, irq}, 16'h0000);

        // framing error, then recovery
        send_frame(8'($urandom), 0);
        bus_read(4'h2, st(0, 0), "status_frame_err");
        check("irq_frame_err", {15'd0, irq}, 16'h0001);
        bus_write(4'hA, 16'h0040);
        ferr_m = 0;
        bus_read(4'h2, st(0, 0), "status_ferr_cleared");
        send_frame(8'($urandom), 1);
        rx_read();

        // RX full, bus pop coincident with a new byte
        for (int i = 0; i < RXD; i++) send_frame(8'($urandom), 1);
        b = 8'($urandom);
        hit = 0;
        fork
            send_frame(b, 1);
            begin
                n = 0;
                while (n < 20 * DIV) begin
                    @(negedge clk);
                    if (dut.u_uart.rx_avail === 1'b1) begin
                        hit = 1;
                        break;
                    end
                    n++;
                end
                tests++;
                if (!hit) begin
                    fails++;
                    $display("FAIL rx_coincident: got no rx_avail expected one");
                end else begin
                    exp_rd_q.push_back({8'h00, rx_q.pop_front()});
                    exp_name_q.push_back("rx_coincident_pop");
                    cs = 1; rd = 1; wr = 0; addr = 4'h0;
                    @(negedge clk);
                    cs = 0; rd = 0;
                end
            end
        join
        bus_read(4'h6, 16'(RXD), "rxcnt_coincident");
        bus_read(4'h2, st(0, 0), "status_no_overrun");
        for (int i = 0; i < RXD; i++) rx_read();

        // reset in the middle of the second byte of a burst
        bus_write(4'h4, 16'h0002);
        for (int i = 0; i < 4; i++) tx_write(8'($urandom), 1);
        repeat (150) @(negedge clk);
        rst = 1;
        tx_exp.delete();
        rx_q.delete();
        ovr_m = 0; ferr_m = 0; tofl_m = 0;
        @(negedge clk);
        check("tx_idle_after_rst", {15'd0, uart_tx}, 16'h0001);
        check("irq_after_rst", {15'd0, irq}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        bus_read(4'h8, 16'h0000, "txcnt_after_rst");
        bus_read(4'h2, st(0, 0), "status_after_rst");
        bus_read(4'h4, 16'h0000, "ctrl_after_rst");
        repeat (3 * 10 * DIV) @(negedge clk);
        check("tx_quiet_after_rst", {15'd0, uart_tx}, 16'h0001);
        check("irq_quiet_after_rst", {15'd0, irq}, 16'h0000);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
